// File: rtl/nmi_xfer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nmi_xfer_pkg
//  Description : Shared types and constants for the NMI transfer master:
//                command record, transfer FSM state encoding, read strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
package nmi_xfer_pkg;

    // One queued bus command. wstrb == NMI_RD_STRB marks a read.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } nmi_cmd_t;

    localparam int CMD_W = $bits(nmi_cmd_t);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } xfer_state_e;

    localparam logic [3:0] NMI_RD_STRB = 4'h0;

endpackage
`default_nettype wire

// File: rtl/nmi_xfer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : nmi_xfer_fifo
//  Description : Generic synchronous first-word-fall-through FIFO.
//                data_o always shows the head entry while empty_o is low.
//  Ports       : clk_i/rst_i   clock, synchronous active-high reset
//                push_i/data_i write side (ignored while full)
//                pop_i/data_o  read side (ignored while empty)
//                full_o/empty_o/count_o  occupancy, all from registered count
//  Revision    : 1.0 - initial release
// ============================================================================
module nmi_xfer_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [DATA_W-1:0]            data_i,
    input  logic                         pop_i,
    output logic [DATA_W-1:0]            data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              w_push;
    logic              w_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push while full is dropped even if a pop happens in the same cycle;
    // the freed slot becomes visible on the following cycle.
    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; only entries between the pointers are observed.
    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/nmi_xfer_master.sv
`default_nettype none
// ============================================================================
//  Module      : nmi_xfer_master
//  Description : Command-driven NMI bus initiator. Queues read/write commands,
//                issues them one at a time on the NMI port, returns read data
//                or write completions in order, and aborts a transfer whose
//                request is held too long without nmi_ready_i.
//  Ports       : cmd_*     command input (valid/ready), wstrb 0 = read
//                rsp_*     response output (valid/ready), err = timed out
//                nmi_*     NMI master port, ready is a one-cycle completion
//                busy_o    work queued or a transfer in flight
//                timeout_cnt_o  saturating count of aborted transfers
//  Revision    : 1.0 - initial release
// ============================================================================
module nmi_xfer_master
    import nmi_xfer_pkg::*;
#(
    parameter int          CMD_DEPTH   = 4,
    parameter int          TIMEOUT_CYC = 1024,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [3:0]  cmd_wstrb_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        nmi_valid_o,
    input  logic        nmi_ready_i,
    output logic [31:0] nmi_addr_o,
    output logic [31:0] nmi_wdata_o,
    output logic [3:0]  nmi_wstrb_o,
    input  logic [31:0] nmi_rdata_i,
    output logic        busy_o,
    output logic [7:0]  timeout_cnt_o
);

    localparam int CNT_W = $clog2(CMD_DEPTH + 1);
    // Keep the watchdog at least one bit wide so a disabled watchdog
    // still elaborates cleanly.
    localparam int WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;

    xfer_state_e       state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [7:0]        tocnt_q, tocnt_d;

    nmi_cmd_t          w_cmd_in;
    nmi_cmd_t          w_cmd_head;
    logic              w_fifo_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_timeout;

    assign w_cmd_in = {cmd_addr_i, cmd_wdata_i, cmd_wstrb_i};

    nmi_xfer_fifo #(
        .DATA_W (CMD_W),
        .DEPTH  (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cmd_valid_i),
        .data_i  (w_cmd_in),
        .pop_i   (w_fifo_pop),
        .data_o  (w_cmd_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    assign w_timeout = (TIMEOUT_CYC != 0) && (wd_q >= WD_LAST);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        wd_d       = wd_q;
        tocnt_d    = tocnt_q;
        w_fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_fifo_pop = 1'b1;
                    addr_d     = w_cmd_head.addr;
                    wdata_d    = w_cmd_head.wdata;
                    wstrb_d    = w_cmd_head.wstrb;
                    wd_d       = '0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                // Completion takes priority over an abort in the same cycle.
                if (nmi_ready_i) begin
                    rdata_d = (wstrb_q == NMI_RD_STRB) ? nmi_rdata_i : 32'h0;
                    err_d   = 1'b0;
                    state_d = RSP;
                end else if (w_timeout) begin
                    rdata_d = ERR_RDATA;
                    err_d   = 1'b1;
                    tocnt_d = (tocnt_q == 8'hFF) ? tocnt_q : tocnt_q + 8'd1;
                    state_d = RSP;
                end else if (TIMEOUT_CYC != 0) begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            RSP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
            tocnt_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            tocnt_q <= tocnt_d;
        end
    end

    assign cmd_ready_o   = ~w_fifo_full;
    assign nmi_valid_o   = (state_q == REQ);
    assign rsp_valid_o   = (state_q == RSP);
    assign nmi_addr_o    = addr_q;
    assign nmi_wdata_o   = wdata_q;
    assign nmi_wstrb_o   = wstrb_q;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign timeout_cnt_o = tocnt_q;
    assign busy_o        = (w_fifo_count != '0) | (state_q != IDLE);

endmodule
`default_nettype wire
